// File: rtl/iadder_b16_6b_pkg.sv
// Shared definitions for the 16-bit segmented approximate adder corrector.
//   - Segment geometry (LSB positions and widths of the five exact-sum segments)
//   - Controller state encoding
//   - Helpers that extract a segment field from a 16-bit word and place it back
package iadder_b16_6b_pkg;

  localparam int unsigned NSEG  = 5;
  localparam int unsigned MAX_W = 6;

  localparam int unsigned SEG_LSB [NSEG] = '{0, 6, 9, 12, 15};
  localparam int unsigned SEG_W   [NSEG] = '{6, 3, 3, 3, 1};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Right-aligned, zero-extended field of segment idx taken from v.
  function automatic logic [MAX_W-1:0] seg_field(input logic [15:0] v,
                                                 input int unsigned idx);
    logic [15:0] sh;
    logic [15:0] m;
    sh = v >> SEG_LSB[idx];
    m  = (16'd1 << SEG_W[idx]) - 16'd1;
    return MAX_W'(sh & m);
  endfunction

  // Inverse of seg_field: bits beyond the segment width are dropped.
  function automatic logic [15:0] seg_place(input logic [MAX_W-1:0] f,
                                            input int unsigned idx);
    logic [15:0] m;
    m = (16'd1 << SEG_W[idx]) - 16'd1;
    return (16'(f) & m) << SEG_LSB[idx];
  endfunction

endpackage

// File: rtl/iadder_b16_6b_corrector_seg_add.sv
// W-bit ripple-carry adder used to recompute one segment of the exact sum.
//   a, b  : W-bit addends
//   cin   : carry in
//   s     : W-bit sum
//   cout  : carry out of bit W-1
module iadder_seg_add #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int unsigned i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/iadder_b16_6b_corrector.sv
// Error detector/corrector for the 16-bit segmented approximate adder.
// Recomputes the exact a+b one segment per clock with a registered carry,
// compares segments 1..4 against the speculative sum and reports a mask of
// wrong segments. Keeps saturating counts of completed and erroneous ops.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only while idle)
//   a, b, approx_sum    : operands and speculative sum
//   out_valid/out_ready : result handshake
//   sum, err_mask, err  : exact sum, per-segment error flags, any-error
//   stat_clr            : synchronous clear of op_cnt / err_cnt
//   op_cnt, err_cnt     : saturating statistics
module iadder_b16_6b_corrector
  import iadder_b16_6b_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [15:0]      approx_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      sum,
  output logic [3:0]       err_mask,
  output logic             err,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t             state_q, state_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [15:0]        ap_q, ap_d;
  logic [15:0]        work_q, work_d;
  logic [3:0]         mask_q, mask_d;
  logic               carry_q, carry_d;
  logic [2:0]         seg_q, seg_d;
  logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  int unsigned        seg_idx;
  logic [MAX_W-1:0]   seg_a, seg_b, seg_ap, seg_s;
  logic               seg_cout;
  logic [MAX_W:0]     seg_full;
  logic               seg_carry;
  logic               seg_diff;

  // Current segment operands, zero-extended into the shared 6-bit adder.
  always_comb begin
    seg_idx = (seg_q < 3'(NSEG)) ? 32'(seg_q) : 0;
    seg_a   = seg_field(a_q,  seg_idx);
    seg_b   = seg_field(b_q,  seg_idx);
    seg_ap  = seg_field(ap_q, seg_idx);
  end

  iadder_seg_add #(.W(MAX_W)) u_seg_add (
    .a    (seg_a),
    .b    (seg_b),
    .cin  (carry_q),
    .s    (seg_s),
    .cout (seg_cout)
  );

  // With zero-extended operands the carry out of a narrow segment appears
  // on the sum bit just above its width; for the full 6-bit segment it is cout.
  always_comb begin
    logic [MAX_W:0] sh;
    seg_full  = {seg_cout, seg_s};
    sh        = seg_full >> SEG_W[seg_idx];
    seg_carry = sh[0];
    seg_diff  = (seg_field(seg_place(seg_s, seg_idx), seg_idx) != seg_ap);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ap_d    = ap_q;
    work_d  = work_q;
    mask_d  = mask_q;
    carry_d = carry_q;
    seg_d   = seg_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          ap_d    = approx_sum;
          work_d  = '0;
          mask_d  = '0;
          carry_d = 1'b0;
          seg_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d  = work_q | seg_place(seg_s, seg_idx);
        carry_d = seg_carry;
        if (seg_q != 3'd0) begin
          mask_d = mask_q | (4'(seg_diff) << (seg_q - 3'd1));
        end
        if (seg_q == 3'(NSEG - 1)) begin
          seg_d   = '0;
          carry_d = 1'b0;
          state_d = DONE;
        end else begin
          seg_d = seg_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_cnt_d  = op_cnt_q;
    err_cnt_d = err_cnt_q;
    if (stat_clr) begin
      op_cnt_d  = '0;
      err_cnt_d = '0;
    end else if (state_q == DONE && out_ready) begin
      if (op_cnt_q != '1) begin
        op_cnt_d = op_cnt_q + 1'b1;
      end
      if ((|mask_q) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      ap_q      <= '0;
      work_q    <= '0;
      mask_q    <= '0;
      carry_q   <= 1'b0;
      seg_q     <= '0;
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ap_q      <= ap_d;
      work_q    <= work_d;
      mask_q    <= mask_d;
      carry_q   <= carry_d;
      seg_q     <= seg_d;
      op_cnt_q  <= op_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = work_q;
  assign err_mask  = mask_q;
  assign err       = |mask_q;
  assign op_cnt    = op_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_iadder_b16_6b_corrector.sv
module tb_iadder_b16_6b_corrector;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   a, b, approx_sum;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   sum;
  logic [3:0]    err_mask;
  logic          err;
  logic          stat_clr;
  logic [CW-1:0] op_cnt, err_cnt;

  iadder_b16_6b_corrector #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .err_mask   (err_mask),
    .err        (err),
    .stat_clr   (stat_clr),
    .op_cnt     (op_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int m_op   = 0;
  int m_err  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: segment i (1..4) wrong when its bits of the true sum differ
  // from the same bits of the speculative sum.
  function automatic logic [3:0] ref_mask(input int exact, input int ap);
    int lsb [5] = '{0, 6, 9, 12, 15};
    int wid [5] = '{6, 3, 3, 3, 1};
    logic [3:0] m;
    m = '0;
    for (int i = 1; i < 5; i++) begin
      int f;
      f = (1 << wid[i]) - 1;
      if (((exact >> lsb[i]) & f) != ((ap >> lsb[i]) & f)) m[i-1] = 1'b1;
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation; hold = cycles of out_ready=0 in DONE with in_valid spam.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] tap,
                        input bit clr, input int hold);
    int es;
    logic [3:0] em;
    int n;
    es = (int'(ta) + int'(tb_)) % 65536;
    em = ref_mask(es, int'(tap));
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    check("in_ready", in_ready, 1);
    a = ta; b = tb_; approx_sum = tap; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); approx_sum = 16'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check("latency", n, 5);
    check("sum", sum, es);
    check("err_mask", err_mask, em);
    check("err", err, |em);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); approx_sum = 16'($urandom);
      step();
      check("hold_sum", sum, es);
      check("hold_mask", err_mask, em);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_op_cnt", op_cnt, m_op);
    end
    in_valid = 1'b0;
    out_ready = 1'b1; stat_clr = clr;
    step();
    out_ready = 1'b0; stat_clr = 1'b0;
    if (clr) begin
      m_op = 0; m_err = 0;
    end else begin
      if (m_op < CMAX) m_op++;
      if (|em && m_err < CMAX) m_err++;
    end
    check("op_cnt", op_cnt, m_op);
    check("err_cnt", err_cnt, m_err);
    check("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    logic [15:0] ra, rb, rap;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
    a = '0; b = '0; approx_sum = '0;
    repeat (2) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_mask", err_mask, 0);
    check("rst_op_cnt", op_cnt, 0);
    rst = 1'b0;
    step();

    run_op(16'h0001, 16'h0002, 16'h0003, 1'b0, 0);
    run_op(16'h003E, 16'h0002, 16'h0000, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 16'h0000, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 16'hFFC0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      case ($urandom_range(0, 2))
        0: rap = ra + rb;
        1: rap = (ra + rb) ^ (16'd1 << $urandom_range(0, 15));
        default: rap = 16'($urandom);
      endcase
      run_op(ra, rb, rap, 1'b0, 0);
    end
    check("op_cnt_sat", op_cnt, CMAX);

    run_op(16'h1234, 16'h4321, 16'h0000, 1'b0, 10);
    run_op(16'h00FF, 16'h0001, 16'h0100, 1'b1, 0);
    run_op(16'h0F0F, 16'h0101, 16'h0000, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 16'h0000, 1'b0, 3);

    // Reset while segment 2 is being computed.
    a = 16'h1111; b = 16'h2222; approx_sum = 16'h0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_mask", err_mask, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_op_cnt", op_cnt, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    m_op = 0; m_err = 0;
    step();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) n++;
    end
    check("post_rst_no_valid", n, 0);
    run_op(16'h7FFF, 16'h0001, 16'h0000, 1'b0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
